enc_emulator: RTL and testbench

Quadrature encoder emulator; the transmit side of the encoder interface. It generates A/B/Z signals from motion commands, each giving an edge count, a direction and an edge period. Used to drive external encoder outputs and to loop back into the encoder input path for self-test of the galvo position loop.

---
 rtl/enc_emulator_pkg.sv | 33 +++
 rtl/enc_emulator_if.sv | 29 ++
 rtl/enc_quad_step.sv | 62 ++++++
 rtl/enc_emulator.sv | 132 +++++++++++++
 tb/tb_enc_emulator.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_emulator_pkg.sv
// Shared definitions for the quadrature encoder emulator.
//   quad_t / Q0..Q3 : {A,B} phase patterns, stepped in order for forward motion
//   DIR_FWD/DIR_REV : command direction encoding (forward = A leads B)
//   state_e         : command sequencer states
//   quad_phase()    : maps the two low index bits to the {A,B} pattern
package enc_pkg;

  typedef logic [1:0] quad_t;

  localparam quad_t Q0 = 2'b00;
  localparam quad_t Q1 = 2'b10;
  localparam quad_t Q2 = 2'b11;
  localparam quad_t Q3 = 2'b01;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic quad_t quad_phase(input logic [1:0] ph);
    case (ph)
      2'd0:    return Q0;
      2'd1:    return Q1;
      2'd2:    return Q2;
      default: return Q3;
    endcase
  endfunction

endpackage

// File: rtl/enc_emulator_if.sv
// Motion-command handshake bundle for enc_emulator.
//   cmd_valid/cmd_ready : command handshake (transfer when both high)
//   cmd_dir             : 1 = forward, 0 = reverse
//   cmd_edges           : quadrature edges to emit (CNT_W)
//   cmd_period          : sys_clk cycles per edge (DIV_W), 0 acts as 1
//   busy                : command in progress
//   done                : one-cycle completion pulse
interface enc_emulator_if #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_edges;
  logic [DIV_W-1:0] cmd_period;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_dir, cmd_edges, cmd_period,
    input  cmd_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_edges, cmd_period,
    output cmd_ready, busy, done
  );
endinterface

// File: rtl/enc_quad_step.sv
// Angular index counter with registered quadrature outputs.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   step, dir        : advance one quadrature state this cycle in direction dir
//   enc_a_out/b/z    : registered A, B and index (Z=1 while idx==0 after a step)
// Index wraps at 4*PPR-1 by explicit compare, so PPR need not be a power of two.
module enc_quad_step
  import enc_pkg::*;
#(
  parameter int unsigned PPR   = 1000,
  parameter int unsigned IDX_W = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic step,
  input  logic dir,
  output logic enc_a_out,
  output logic enc_b_out,
  output logic enc_z_out
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(4 * PPR - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             z_q, z_d;

  always_comb begin
    idx_d = idx_q;
    a_d   = a_q;
    b_d   = b_q;
    z_d   = z_q;
    if (step) begin
      if (dir == DIR_FWD) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end else begin
        idx_d = (idx_q == '0) ? IDX_MAX : idx_q - IDX_W'(1);
      end
      {a_d, b_d} = quad_phase(idx_d[1:0]);
      z_d        = (idx_d == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q <= '0;
      a_q   <= 1'b0;
      b_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      z_q   <= z_d;
    end
  end

  assign enc_a_out = a_q;
  assign enc_b_out = b_q;
  assign enc_z_out = z_q;

endmodule

// File: rtl/enc_emulator.sv
// Quadrature encoder emulator: turns motion commands (edge count, direction,
// edge period) into A/B/Z encoder waveforms.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   emu_en           : run enable; low pauses emission and blocks acceptance
//   cmd              : command handshake bundle (slave side), incl. busy/done
//   enc_a_out/b/z    : encoder phase A, phase B, index
//   pos_clr, pos_out : position clear / signed position count, present only
//                      when ENC_EMU_POS_EN is defined
module enc_emulator
  import enc_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned PPR   = 1000,
  parameter int unsigned IDX_W = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                emu_en,
  enc_emulator_if.slave       cmd,
  output logic                enc_a_out,
  output logic                enc_b_out,
  output logic                enc_z_out
`ifdef ENC_EMU_POS_EN
  ,
  input  logic                pos_clr,
  output logic signed [31:0]  pos_out
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             step;
  logic             accept;

  // FINISH reports busy=0, so ready is high there too; it accepts exactly like
  // IDLE so that an asserted ready is never a dropped handshake.
  assign cmd.busy      = (state_q == RUN);
  assign cmd.done      = (state_q == FINISH);
  assign cmd.cmd_ready = !cmd.busy && emu_en;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step     = 1'b0;
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (accept) begin
          dir_d    = cmd.cmd_dir;
          period_d = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;
          timer_d  = period_d;
          cnt_d    = cmd.cmd_edges;
          state_d  = (cmd.cmd_edges == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        // Count exhaustion is seen the cycle after the last edge, which puts
        // done one cycle behind that edge.
        if (cnt_q == '0) begin
          state_d = FINISH;
        end else if (emu_en) begin
          if (timer_q == DIV_W'(1)) begin
            step    = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            timer_d = period_q;
          end else begin
            timer_d = timer_q - DIV_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_FWD;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
    end
  end

  enc_quad_step #(
    .PPR   (PPR),
    .IDX_W (IDX_W)
  ) u_quad_step (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .step      (step),
    .dir       (dir_q),
    .enc_a_out (enc_a_out),
    .enc_b_out (enc_b_out),
    .enc_z_out (enc_z_out)
  );

`ifdef ENC_EMU_POS_EN
  logic signed [31:0] pos_q, pos_d;

  always_comb begin
    pos_d = pos_q;
    if (pos_clr) begin
      pos_d = '0;
    end else if (step) begin
      pos_d = (dir_q == DIR_FWD) ? pos_q + 32'sd1 : pos_q - 32'sd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) pos_q <= '0;
    else         pos_q <= pos_d;
  end

  assign pos_out = pos_q;
`endif

endmodule

// File: tb/tb_enc_emulator.sv
module tb_enc_emulator;
  localparam int CNT_W = 16;
  localparam int DIV_W = 16;
  localparam int PPR   = 4;
  localparam int IDX_W = 16;
  localparam int NST   = 4 * PPR;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic emu_en  = 1'b0;
  logic enc_a, enc_b, enc_z;
  logic rand_mode = 1'b0;
`ifdef ENC_EMU_POS_EN
  logic               pos_clr = 1'b0;
  logic signed [31:0] pos_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  enc_emulator_if #(.CNT_W(CNT_W), .DIV_W(DIV_W)) cmd_if ();

  always #5 sys_clk = ~sys_clk;

  enc_emulator #(
    .CNT_W (CNT_W),
    .DIV_W (DIV_W),
    .PPR   (PPR),
    .IDX_W (IDX_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .emu_en    (emu_en),
    .cmd       (cmd_if),
    .enc_a_out (enc_a),
    .enc_b_out (enc_b),
    .enc_z_out (enc_z)
`ifdef ENC_EMU_POS_EN
    ,
    .pos_clr   (pos_clr),
    .pos_out   (pos_out)
`endif
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks the angular position and the command as
  // "enabled cycles elapsed since acceptance"; an edge falls on every multiple
  // of the period, and done appears one cycle after the final edge.
  int m_idx = 0, m_e = 0, m_n = 0, m_p = 1;
  bit m_dir = 1'b1, m_active = 1'b0, m_fin = 1'b0, m_done = 1'b0, m_z = 1'b0;
  longint m_pos = 0;

  function automatic logic [1:0] ab_of(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  always begin
    bit stepped;
    @(posedge sys_clk);
    stepped = 1'b0;
    if (sys_rst) begin
      m_idx = 0; m_z = 1'b0; m_active = 1'b0; m_fin = 1'b0; m_done = 1'b0; m_pos = 0;
    end else begin
      m_done = 1'b0;
      if (m_fin) begin
        m_fin = 1'b0; m_active = 1'b0; m_done = 1'b1;
      end else if (m_active) begin
        if (emu_en) begin
          m_e++;
          if (m_e % m_p == 0) begin
            stepped = 1'b1;
            m_idx = m_dir ? (m_idx + 1) % NST : (m_idx + NST - 1) % NST;
            m_z   = (m_idx == 0);
            if (m_e == m_n * m_p) m_fin = 1'b1;
          end
        end
      end else if (cmd_if.cmd_valid && emu_en) begin
        m_dir = cmd_if.cmd_dir;
        m_n   = int'(cmd_if.cmd_edges);
        m_p   = (cmd_if.cmd_period == 0) ? 1 : int'(cmd_if.cmd_period);
        m_e   = 0;
        if (m_n == 0) m_done = 1'b1;
        else          m_active = 1'b1;
      end
`ifdef ENC_EMU_POS_EN
      if (pos_clr)      m_pos = 0;
      else if (stepped) m_pos = m_dir ? m_pos + 1 : m_pos - 1;
`endif
    end
    #1;
    chk("ab",    {enc_a, enc_b}, ab_of(m_idx));
    chk("z",     enc_z, m_z);
    chk("busy",  cmd_if.busy, m_active);
    chk("done",  cmd_if.done, m_done);
    chk("ready", cmd_if.cmd_ready, emu_en && !m_active);
`ifdef ENC_EMU_POS_EN
    chk("pos",   pos_out, m_pos);
`endif
  end

  always @(negedge sys_clk) begin
    if (rand_mode) begin
      emu_en = ($urandom_range(0, 3) != 0);
`ifdef ENC_EMU_POS_EN
      pos_clr = ($urandom_range(0, 19) == 0);
`endif
    end
  end

  // Presents a command and returns just after the accepting clock edge.
  task automatic send_cmd(input bit dir, input int n, input int p);
    int k;
    @(negedge sys_clk);
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_edges  = CNT_W'(n);
    cmd_if.cmd_period = DIV_W'(p);
    cmd_if.cmd_valid  = 1'b1;
    for (k = 0; k < 2000; k++) begin
      if (cmd_if.cmd_ready) break;
      @(negedge sys_clk);
    end
    if (k == 2000) chk("accept_timeout", 0, 1);
    @(posedge sys_clk);
    #2;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge sys_clk);
      if (!cmd_if.busy && !cmd_if.done) break;
    end
    if (k == 3000) chk("idle_timeout", 0, 1);
  endtask

  // Runs a command, optionally pausing emu_en, and checks cycles from the
  // accepting edge to the first cycle done is seen.
  task automatic run_cmd(input bit dir, input int n, input int p,
                         input int pause_at, input int pause_len, input int exp_lat);
    int c;
    bit got;
    send_cmd(dir, n, p);
    got = 1'b0;
    for (c = 0; c < 3000; c++) begin
      @(negedge sys_clk);
      if (cmd_if.done) begin got = 1'b1; break; end
      if (pause_len > 0 && c == pause_at)             emu_en = 1'b0;
      if (pause_len > 0 && c == pause_at + pause_len) emu_en = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("latency", c, exp_lat);
    @(negedge sys_clk);
  endtask

  task automatic pulse_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_edges  = '0;
    cmd_if.cmd_period = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    emu_en  = 1'b1;
    chk("rst_ab", {enc_a, enc_b}, 2'b00);
    chk("rst_z", enc_z, 0);
    chk("rst_busy", cmd_if.busy, 0);

    // full forward revolution
    run_cmd(1'b1, 16, 3, 0, 0, 49);
    chk("rev_ab", {enc_a, enc_b}, 2'b00);
    chk("rev_z", enc_z, 1);

    // wrap both ways from reset
    pulse_reset();
    run_cmd(1'b0, 1, 2, 0, 0, 3);
    chk("wrap_rev_ab", {enc_a, enc_b}, 2'b01);
    chk("wrap_rev_z", enc_z, 0);
    run_cmd(1'b1, 1, 2, 0, 0, 3);
    chk("wrap_fwd_ab", {enc_a, enc_b}, 2'b00);
    chk("wrap_fwd_z", enc_z, 1);

    // zero edges, then zero period
    run_cmd(1'b1, 0, 5, 0, 0, 0);
    chk("zero_edges_z", enc_z, 1);
    run_cmd(1'b1, 4, 0, 0, 0, 5);

    // 10-cycle pause mid-run
    run_cmd(1'b0, 8, 4, 12, 10, 43);

    // command while busy is ignored
    send_cmd(1'b1, 8, 2);
    @(negedge sys_clk);
    cmd_if.cmd_dir = 1'b0; cmd_if.cmd_edges = 16'd3; cmd_if.cmd_period = 16'd1;
    cmd_if.cmd_valid = 1'b1;
    repeat (4) @(negedge sys_clk);
    cmd_if.cmd_valid = 1'b0;
    wait_done();

    // reset mid-command, then a normal command
    send_cmd(1'b1, 10, 2);
    repeat (5) @(negedge sys_clk);
    pulse_reset();
    chk("midrst_ab", {enc_a, enc_b}, 2'b00);
    chk("midrst_z", enc_z, 0);
    chk("midrst_busy", cmd_if.busy, 0);
    chk("midrst_done", cmd_if.done, 0);
    run_cmd(1'b1, 3, 1, 0, 0, 4);

    // randomized commands with random enable, garbage and resets
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int r;
      send_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 4));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge sys_clk);
        pulse_reset();
      end else if (r == 1) begin
        @(negedge sys_clk);
        cmd_if.cmd_dir = 1'($urandom_range(0, 1));
        cmd_if.cmd_edges = CNT_W'($urandom_range(0, 5));
        cmd_if.cmd_valid = 1'b1;
        repeat (3) @(negedge sys_clk);
        cmd_if.cmd_valid = 1'b0;
      end
      wait_done();
    end
    rand_mode = 1'b0;
    @(negedge sys_clk);
    emu_en = 1'b1;
`ifdef ENC_EMU_POS_EN
    pos_clr = 1'b0;
`endif
    wait_done();
    repeat (3) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
